// File: rtl/reg_file_pkg.sv
// +----------------------------------------------------------------------+
// | reg_file_pkg : shared types and default widths for reg_file_mp       |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package reg_file_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
// +----------------------------------------------------------------------+
// | reg_file_scoreboard : per-register pending bits for in-flight loads  |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_file_scoreboard #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_set_en,
   input  logic [ADDR_W-1:0] i_set_addr,
   input  logic              i_clr_en,
   input  logic [ADDR_W-1:0] i_clr_addr,
   input  logic              i_idx_clr_en,
   input  logic [ADDR_W-1:0] i_idx_clr_addr,
   output logic [DEPTH-1:0]  o_pending
);

   logic [DEPTH-1:0] r_pend;

   // Later assignments win: a claim overrides a same-cycle writeback clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         if (i_clr_en)     r_pend[i_clr_addr]     <= 1'b0;
         if (i_idx_clr_en) r_pend[i_idx_clr_addr] <= 1'b0;
         if (i_set_en)     r_pend[i_set_addr]     <= 1'b1;
      end
   end

   assign o_pending = r_pend;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// +----------------------------------------------------------------------+
// | reg_file_mp : multi-port register file with bypass, load scoreboard  |
// |               and sequential clear engine                            |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
   output logic [NUM_RD*DATA_W-1:0] o_rd_data,
   output logic [NUM_RD-1:0]        o_rd_pending,
   input  logic                     i_wa_en,
   input  logic [ADDR_W-1:0]        i_wa_addr,
   input  logic [DATA_W-1:0]        i_wa_data,
   input  logic                     i_wb_en,
   input  logic [ADDR_W-1:0]        i_wb_addr,
   input  logic [DATA_W-1:0]        i_wb_data,
   input  logic                     i_claim_en,
   input  logic [ADDR_W-1:0]        i_claim_addr,
   input  logic                     i_clear_req,
   output logic                     o_clear_busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic c_zero_reg = (ZERO_REG != 0);

   logic [DATA_W-1:0] r_mem [DEPTH];
   clr_state_e        r_state;
   logic [ADDR_W-1:0] r_idx;

   logic              w_busy;
   logic              w_wa_ok;
   logic              w_wb_ok;
   logic              w_claim_ok;
   logic              w_wb_act;
   logic [DEPTH-1:0]  w_pend;

   assign w_busy     = (r_state == ST_CLEAR);
   assign w_wa_ok    = i_wa_en    & ~w_busy & ~(c_zero_reg & (i_wa_addr    == '0));
   assign w_wb_ok    = i_wb_en    & ~w_busy & ~(c_zero_reg & (i_wb_addr    == '0));
   assign w_claim_ok = i_claim_en & ~w_busy & ~(c_zero_reg & (i_claim_addr == '0));
   assign w_wb_act   = i_wb_en    & ~w_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_state <= ST_IDLE;
         r_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_wa_ok) r_mem[i_wa_addr] <= i_wa_data;
               if (w_wb_ok) r_mem[i_wb_addr] <= i_wb_data;
               if (i_clear_req) begin
                  r_state <= ST_CLEAR;
                  r_idx   <= '0;
               end
            end
            ST_CLEAR: begin
               r_mem[r_idx] <= '0;
               r_idx        <= r_idx + 1'b1;
               if (&r_idx) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   reg_file_scoreboard #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_scoreboard (
      .clk            (clk),
      .rst            (rst),
      .i_set_en       (w_claim_ok),
      .i_set_addr     (i_claim_addr),
      .i_clr_en       (w_wb_act),
      .i_clr_addr     (i_wb_addr),
      .i_idx_clr_en   (w_busy),
      .i_idx_clr_addr (r_idx),
      .o_pending      (w_pend)
   );

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] w_a;
      logic [DATA_W-1:0] w_d;

      assign w_a = i_rd_addr[g*ADDR_W +: ADDR_W];

      // Port B is checked first so the bypass matches the write priority.
      always_comb begin
         w_d = r_mem[w_a];
         if (!w_busy) begin
            if (i_wb_en && (i_wb_addr == w_a))      w_d = i_wb_data;
            else if (i_wa_en && (i_wa_addr == w_a)) w_d = i_wa_data;
         end
         if (c_zero_reg && (w_a == '0)) w_d = '0;
      end

      assign o_rd_data[g*DATA_W +: DATA_W] = w_d;
      assign o_rd_pending[g] = ~w_busy & w_pend[w_a] & ~(w_wb_act & (i_wb_addr == w_a));
   end

   assign o_clear_busy = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// +----------------------------------------------------------------------+
// | tb_reg_file_mp : directed + random checks of reg_file_mp vs a model  |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reg_file_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int DEPTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_pending;
   logic             wa_en, wb_en, claim_en, clear_req, clear_busy;
   logic [AW-1:0]    wa_addr, wb_addr, claim_addr;
   logic [DW-1:0]    wa_data, wb_data;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] m_mem  [DEPTH];
   bit            m_pend [DEPTH];
   int            m_left;
   logic [DW-1:0] n_mem  [DEPTH];
   bit            n_pend [DEPTH];
   int            n_left;

   always #5 clk = ~clk;

   reg_file_mp #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_rd_addr    (rd_addr),
      .o_rd_data    (rd_data),
      .o_rd_pending (rd_pending),
      .i_wa_en      (wa_en),
      .i_wa_addr    (wa_addr),
      .i_wa_data    (wa_data),
      .i_wb_en      (wb_en),
      .i_wb_addr    (wb_addr),
      .i_wb_data    (wb_data),
      .i_claim_en   (claim_en),
      .i_claim_addr (claim_addr),
      .i_clear_req  (clear_req),
      .o_clear_busy (clear_busy)
   );

   task automatic quiet();
      rst = 1'b0; wa_en = 1'b0; wb_en = 1'b0; claim_en = 1'b0; clear_req = 1'b0;
      wa_addr = '0; wb_addr = '0; claim_addr = '0; wa_data = '0; wb_data = '0;
   endtask

   task automatic set_rd(input int p, input int a);
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic check_all();
      logic [DW-1:0] exp_d;
      bit            exp_p;
      bit            busy;
      int            a;
      busy = (m_left > 0);
      for (int p = 0; p < NR; p++) begin
         a = int'(rd_addr[p*AW +: AW]);
         if (busy) begin
            exp_d = m_mem[a];
            exp_p = 1'b0;
         end else begin
            if (wb_en && int'(wb_addr) == a)      exp_d = wb_data;
            else if (wa_en && int'(wa_addr) == a) exp_d = wa_data;
            else                                  exp_d = m_mem[a];
            exp_p = m_pend[a] && !(wb_en && int'(wb_addr) == a);
         end
         if (a == 0) begin
            exp_d = '0;
            exp_p = 1'b0;
         end
         checks++;
         assert (rd_data[p*DW +: DW] === exp_d) else begin
            errors++;
            $error("FAIL rd_data[%0d] addr=%0d observed=%h expected=%h", p, a, rd_data[p*DW +: DW], exp_d);
         end
         checks++;
         assert (rd_pending[p] === exp_p) else begin
            errors++;
            $error("FAIL rd_pending[%0d] addr=%0d observed=%b expected=%b", p, a, rd_pending[p], exp_p);
         end
      end
      checks++;
      assert (clear_busy === busy) else begin
         errors++;
         $error("FAIL clear_busy observed=%b expected=%b", clear_busy, busy);
      end
   endtask

   // Check the current cycle, then advance the model by one clock edge.
   task automatic tick();
      #2;
      check_all();
      n_mem = m_mem; n_pend = m_pend; n_left = m_left;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin n_mem[i] = '0; n_pend[i] = 1'b0; end
         n_left = 0;
      end else if (m_left > 0) begin
         n_mem[DEPTH - m_left]  = '0;
         n_pend[DEPTH - m_left] = 1'b0;
         n_left = m_left - 1;
      end else begin
         if (wa_en && wa_addr != 0) n_mem[wa_addr] = wa_data;
         if (wb_en && wb_addr != 0) n_mem[wb_addr] = wb_data;
         if (wb_en) n_pend[wb_addr] = 1'b0;
         if (claim_en && claim_addr != 0) n_pend[claim_addr] = 1'b1;
         if (clear_req) n_left = DEPTH;
      end
      @(posedge clk);
      #1;
      m_mem = n_mem; m_pend = n_pend; m_left = n_left;
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a += NR) begin
         for (int p = 0; p < NR; p++) set_rd(p, a + p);
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 'x; m_pend[i] = 1'b0; end
      m_left = 0;
      rd_addr = '0;
      quiet();
      rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      quiet();
      read_all();

      // Port A bypass then array read-back
      wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; set_rd(0, 5); set_rd(1, 4);
      tick();
      wa_en = 0;
      tick();

      // Both ports to the same address
      wa_en = 1; wa_addr = 7; wa_data = 32'h1111;
      wb_en = 1; wb_addr = 7; wb_data = 32'h2222; set_rd(0, 7); set_rd(1, 5);
      tick();
      quiet();
      tick();

      // Zero register ignores writes and claims
      wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF;
      wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF; set_rd(0, 0); set_rd(1, 0);
      tick();
      quiet(); claim_en = 1; claim_addr = 0;
      tick();
      quiet();
      tick();

      // Scoreboard: claim, claim+wb same cycle, wb alone
      claim_en = 1; claim_addr = 9; set_rd(0, 9); set_rd(1, 0);
      tick();
      quiet();
      tick();
      claim_en = 1; claim_addr = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h99;
      tick();
      quiet();
      tick();
      wb_en = 1; wb_addr = 9; wb_data = 32'h9A;
      tick();
      quiet();
      tick();

      // Fill, then a full clear with a write and claim arriving mid-clear
      for (int a = 1; a < DEPTH; a++) begin
         wa_en = 1; wa_addr = AW'(a); wa_data = $urandom; set_rd(0, a);
         claim_en = 1; claim_addr = AW'(DEPTH - a);
         tick();
      end
      quiet();
      clear_req = 1;
      tick();
      clear_req = 0;
      for (int c = 0; c < DEPTH; c++) begin
         set_rd(0, c); set_rd(1, (c + 3) % DEPTH);
         if (c == 4) begin
            wa_en = 1; wa_addr = 20; wa_data = 32'hBAD0BAD0;
            claim_en = 1; claim_addr = 21; clear_req = 1;
         end else begin
            quiet();
         end
         tick();
      end
      quiet();
      read_all();

      // Clear interrupted by reset
      for (int a = 1; a < DEPTH; a++) begin
         wb_en = 1; wb_addr = AW'(a); wb_data = $urandom; set_rd(1, a);
         tick();
      end
      quiet();
      clear_req = 1;
      tick();
      quiet();
      for (int c = 0; c < 9; c++) tick();
      rst = 1;
      tick();
      rst = 0;
      tick();
      read_all();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         quiet();
         for (int p = 0; p < NR; p++) set_rd(p, $urandom_range(0, 7));
         wa_en = ($urandom_range(0, 1) == 1);
         wa_addr = AW'($urandom_range(0, 7)); wa_data = $urandom;
         wb_en = ($urandom_range(0, 9) < 4);
         wb_addr = AW'($urandom_range(0, 7)); wb_data = $urandom;
         claim_en = ($urandom_range(0, 9) < 3);
         claim_addr = AW'($urandom_range(0, 7));
         clear_req = ($urandom_range(0, 79) == 0);
         rst = ($urandom_range(0, 149) == 0);
         tick();
      end
      quiet();
      read_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
